// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one single-ported RAM between CPUS cores. Each core has an
//   instruction requester (iREN) and a data requester (dREN/dWEN). Cores are
//   picked round-robin; inside a core the data request wins over the
//   instruction fetch. One transaction runs at a time: IDLE -> BUSY -> DONE.
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   iREN, iaddr           per-core instruction read request / address
//   dREN, dWEN            per-core data read / write request (both = write)
//   daddr, dstore         per-core data address / write data
//   iwait, dwait          per-requester wait, low for one cycle on completion
//   iload, dload          per-core returned word, held until overwritten
//   ramstate, ramload     RAM status (FREE/BUSY/ACCESS/ERROR) and read data
//   ramREN, ramWEN        RAM command strobes
//   ramaddr, ramstore     RAM address / write data
//   grant_id              core owning the RAM (valid in BUSY/DONE)
//   err                   per-core timeout pulse
//   Per-core 32-bit buses are packed core-major: core c at [c*32 +: 32].
//
// Build option
//   MEMARB_TIMEOUT_EN     adds a BUSY watchdog of TIMEOUT cycles; on expiry the
//                         transaction is closed, reads return 32'hBAD1BAD1 and
//                         err[core] pulses with the wait pulse. Without it the
//                         arbiter waits for ACCESS indefinitely and err is 0.
module memory_arbiter #(
    parameter int unsigned CPUS    = 2,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned GW     = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [32*CPUS-1:0]   iaddr,
    input  logic [32*CPUS-1:0]   daddr,
    input  logic [32*CPUS-1:0]   dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [32*CPUS-1:0]   iload,
    output logic [32*CPUS-1:0]   dload,
    input  logic [1:0]           ramstate,
    input  logic [31:0]          ramload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    output logic [GW-1:0]        grant_id,
    output logic [CPUS-1:0]      err
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ram_state_e;

    if (TIMEOUT == 0) begin : g_timeout_check
        $error("memory_arbiter: TIMEOUT must be at least 1");
    end

    state_e        state_q, state_d;
    logic [GW-1:0] rr_q, rr_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic          is_data_q, is_data_d;
    logic          is_write_q, is_write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   store_q, store_d;
    logic [31:0]   iload_q [CPUS];
    logic [31:0]   iload_d [CPUS];
    logic [31:0]   dload_q [CPUS];
    logic [31:0]   dload_d [CPUS];

`ifdef MEMARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
`endif

    logic [31:0]   iaddr_a  [CPUS];
    logic [31:0]   daddr_a  [CPUS];
    logic [31:0]   dstore_a [CPUS];
    logic          found;
    logic [GW-1:0] sel;
    logic [GW-1:0] cand;
    int unsigned   idx;

    // Unpack the flat per-core buses and repack the load registers.
    always_comb begin
        for (int unsigned c = 0; c < CPUS; c++) begin
            iaddr_a[c]         = iaddr[c*32 +: 32];
            daddr_a[c]         = daddr[c*32 +: 32];
            dstore_a[c]        = dstore[c*32 +: 32];
            iload[c*32 +: 32]  = iload_q[c];
            dload[c*32 +: 32]  = dload_q[c];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        is_data_d  = is_data_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        store_d    = store_q;
        iload_d    = iload_q;
        dload_d    = dload_q;
        found      = 1'b0;
        sel        = '0;
        cand       = '0;
        idx        = 0;
`ifdef MEMARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                // First core with any request, scanning upward from rr_q.
                for (int unsigned i = 0; i < CPUS; i++) begin
                    idx = rr_q + i;
                    if (idx >= CPUS) idx = idx - CPUS;
                    cand = GW'(idx);
                    if (!found && (dREN[cand] || dWEN[cand] || iREN[cand])) begin
                        found = 1'b1;
                        sel   = cand;
                    end
                end
                if (found) begin
                    gnt_d      = sel;
                    is_data_d  = dREN[sel] || dWEN[sel];
                    is_write_d = dWEN[sel];
                    addr_d     = is_data_d ? daddr_a[sel] : iaddr_a[sel];
                    store_d    = dstore_a[sel];
                    state_d    = S_BUSY;
`ifdef MEMARB_TIMEOUT_EN
                    cnt_d      = '0;
                    tmo_d      = 1'b0;
`endif
                end
            end
            S_BUSY: begin
                if (ramstate == RAM_ACCESS) begin
                    if (!is_write_q) begin
                        if (is_data_q) dload_d[gnt_q] = ramload;
                        else           iload_d[gnt_q] = ramload;
                    end
                    state_d = S_DONE;
                end
`ifdef MEMARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    if (!is_write_q) begin
                        if (is_data_q) dload_d[gnt_q] = 32'hBAD1_BAD1;
                        else           iload_d[gnt_q] = 32'hBAD1_BAD1;
                    end
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                rr_d    = (gnt_q == GW'(CPUS - 1)) ? '0 : gnt_q + 1'b1;
                state_d = S_IDLE;
`ifdef MEMARB_TIMEOUT_EN
                tmo_d   = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: strobes only in BUSY, the single wait pulse only in DONE.
    always_comb begin
        iwait    = '1;
        dwait    = '1;
        err      = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = addr_q;
        ramstore = store_q;
        grant_id = gnt_q;
        case (state_q)
            S_BUSY: begin
                ramWEN = is_write_q;
                ramREN = !is_write_q;
            end
            S_DONE: begin
                if (is_data_q) dwait[gnt_q] = 1'b0;
                else           iwait[gnt_q] = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
                err[gnt_q] = tmo_q;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            gnt_q      <= '0;
            is_data_q  <= 1'b0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            store_q    <= '0;
            iload_q    <= '{default: '0};
            dload_q    <= '{default: '0};
`ifdef MEMARB_TIMEOUT_EN
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            is_data_q  <= is_data_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            store_q    <= store_d;
            iload_q    <= iload_d;
            dload_q    <= dload_d;
`ifdef MEMARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

endmodule
